// File: rtl/if_fetch_redirect.sv
// rtl/if_fetch_redirect.sv - fetch stage: PC owner, single-outstanding imem reads, one-entry decode buffer, redirect/squash
module if_fetch_redirect #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pcmux_sel,
    input  logic [15:0] br_addr,
    input  logic        id_stall,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        imem_read,
    output logic [15:0] imem_address,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        flush_id,
    output logic        flush_ex
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ifpc_q, ifpc_d;

    logic redir;
    logic room;

    assign redir = (pcmux_sel != 2'b00);
    // A new read may only issue when the buffer is empty or draining this cycle,
    // so a response can never land on an undrained entry.
    assign room  = !valid_q || !id_stall;

    assign flush_id     = redir;
    assign flush_ex     = redir;
    assign imem_read    = (state_q != IDLE);
    assign imem_address = addr_q;
    assign if_valid     = valid_q;
    assign if_instr     = instr_q;
    assign if_pc        = ifpc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;

        if (valid_q && !id_stall) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!redir && room) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (redir) begin
                    state_d = imem_resp ? IDLE : SQUASH;
                end else if (imem_resp) begin
                    instr_d = imem_rdata;
                    ifpc_d  = addr_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 16'd2;
                    state_d = IDLE;
                end
            end
            SQUASH: begin
                // The stale read must still complete; its data is thrown away.
                if (imem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redir) begin
            pc_d    = br_addr & 16'hFFFE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= 16'h0000;
            valid_q <= 1'b0;
            instr_q <= 16'h0000;
            ifpc_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_redirect.sv
// tb/tb_if_fetch_redirect.sv - table-driven bench for if_fetch_redirect
module tb_if_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pcmux_sel;
    logic [15:0] br_addr;
    logic        id_stall;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        flush_id;
    logic        flush_ex;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_redirect #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcmux_sel    (pcmux_sel),
        .br_addr      (br_addr),
        .id_stall     (id_stall),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] br;
        logic        stall;
        logic        resp;
        logic [15:0] rdata;
        logic        flush;
        logic        rd;
        logic [15:0] addr;
        logic        v;
        logic [15:0] instr;
        logic [15:0] ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] sel, input logic [15:0] br, input logic stall,
                       input logic resp, input logic [15:0] rdata, input logic flush,
                       input logic rd, input logic [15:0] addr, input logic v,
                       input logic [15:0] instr, input logic [15:0] ipc);
        vec_t r;
        r.sel = sel; r.br = br; r.stall = stall; r.resp = resp; r.rdata = rdata;
        r.flush = flush; r.rd = rd; r.addr = addr; r.v = v; r.instr = instr; r.ipc = ipc;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic rd, input logic [15:0] addr,
                              input logic v, input logic [15:0] instr, input logic [15:0] ipc);
        check("imem_read",    idx, {15'd0, imem_read}, {15'd0, rd});
        check("imem_address", idx, imem_address, addr);
        check("if_valid",     idx, {15'd0, if_valid}, {15'd0, v});
        check("if_instr",     idx, if_instr, instr);
        check("if_pc",        idx, if_pc, ipc);
    endtask

    initial begin
        rst_n = 1'b0; pcmux_sel = 2'b00; br_addr = 16'h0000; id_stall = 1'b0;
        imem_resp = 1'b0; imem_rdata = 16'h0000;

        // sequential fetch, response two cycles after request
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(2'd0, 16'h0000, 0, 1, 16'h1234, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000);
        // decode stalled: no new request while the buffer is full
        for (int i = 0; i < 5; i++)
            add(2'd0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000);
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'h1234, 16'h0000);
        add(2'd0, 16'h0000, 0, 1, 16'hABCD, 0, 0, 16'h0002, 1, 16'hABCD, 16'h0002);
        // redirect while REQ at 0x0004 is outstanding
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'hABCD, 16'h0002);
        add(2'd1, 16'h3001, 0, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'hABCD, 16'h0002);
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'hABCD, 16'h0002);
        add(2'd0, 16'h0000, 0, 1, 16'h5555, 0, 0, 16'h0004, 0, 16'hABCD, 16'h0002);
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h3000, 0, 16'hABCD, 16'h0002);
        // redirect coincident with response: data dropped
        add(2'd2, 16'h3000, 0, 1, 16'h7777, 1, 0, 16'h3000, 0, 16'hABCD, 16'h0002);
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h3000, 0, 16'hABCD, 16'h0002);
        add(2'd0, 16'h0000, 0, 1, 16'h1111, 0, 0, 16'h3000, 1, 16'h1111, 16'h3000);
        // redirect from IDLE to odd target, then wrap at 0xFFFE
        add(2'd3, 16'hFFFF, 0, 0, 16'h0000, 1, 0, 16'h3000, 0, 16'h1111, 16'h3000);
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hFFFE, 0, 16'h1111, 16'h3000);
        add(2'd0, 16'h0000, 0, 1, 16'h2222, 0, 0, 16'hFFFE, 1, 16'h2222, 16'hFFFE);
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h2222, 16'hFFFE);
        // two redirects while squashing: last target wins
        add(2'd1, 16'h0100, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h2222, 16'hFFFE);
        add(2'd1, 16'h0200, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h2222, 16'hFFFE);
        add(2'd0, 16'h0000, 0, 1, 16'h6666, 0, 0, 16'h0000, 0, 16'h2222, 16'hFFFE);
        add(2'd0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0200, 0, 16'h2222, 16'hFFFE);
        add(2'd0, 16'h0000, 0, 1, 16'h4444, 0, 0, 16'h0200, 1, 16'h4444, 16'h0200);
        // response strobe in IDLE is ignored
        add(2'd0, 16'h0000, 1, 1, 16'h9999, 0, 0, 16'h0200, 1, 16'h4444, 16'h0200);

        repeat (2) @(posedge clk);
        #1 check_outs(-1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            pcmux_sel = vecs[i].sel; br_addr = vecs[i].br; id_stall = vecs[i].stall;
            imem_resp = vecs[i].resp; imem_rdata = vecs[i].rdata;
            #1;
            check("flush_id", i, {15'd0, flush_id}, {15'd0, vecs[i].flush});
            check("flush_ex", i, {15'd0, flush_ex}, {15'd0, vecs[i].flush});
            @(posedge clk);
            #1 check_outs(i, vecs[i].rd, vecs[i].addr, vecs[i].v, vecs[i].instr, vecs[i].ipc);
            @(negedge clk);
        end

        // asynchronous reset in the middle of an outstanding read
        pcmux_sel = 2'b00; id_stall = 1'b0; imem_resp = 1'b0;
        @(posedge clk);
        #1 check_outs(100, 1'b1, 16'h0202, 1'b0, 16'h4444, 16'h0200);
        #2 rst_n = 1'b0;
        #1 check_outs(101, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1; imem_resp = 1'b1; imem_rdata = 16'hDEAD;
        @(posedge clk);
        #1 check_outs(102, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        imem_resp = 1'b0;
        @(posedge clk);
        #1 check_outs(103, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        imem_resp = 1'b1; imem_rdata = 16'h0BAD;
        @(posedge clk);
        #1 check_outs(104, 1'b0, 16'h0000, 1'b1, 16'h0BAD, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
